// File: rtl/crc_ser_pkg.sv
// crc_ser_pkg: FSM state encodings, default widths and counter-width helper
// shared by the CRC frame serializer and its byte buffer.
package crc_ser_pkg;
   localparam logic [1:0] ST_COLLECT  = 2'd0;
   localparam logic [1:0] ST_SEND     = 2'd1;
   localparam logic [1:0] ST_CRC_WAIT = 2'd2;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MAX_BYTES  = 4;
   localparam int DEF_CRC_WIDTH  = 8;
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/crc_ser_buf.sv
// crc_ser_buf: frame byte store, written in arrival order, read combinationally by byte index.
module crc_ser_buf
   import crc_ser_pkg::*;
#(
   parameter int DW = DEF_DATA_WIDTH,
   parameter int MB = DEF_MAX_BYTES,
   parameter int BW = cnt_w(MB + 1),
   parameter int AW = cnt_w(MB)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wr_en,
   input  logic          clr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_idx,
   output logic [BW-1:0] count,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [MB];
   always_ff @(posedge CLK or negedge RST)
      if (!RST) count <= '0;
      else if (clr) count <= '0;
      else if (wr_en) count <= count + 1'b1;
   // data needs no reset: a byte is only read after it has been written
   always_ff @(posedge CLK)
      if (wr_en) mem[count[AW-1:0]] <= wr_data;
   assign rd_data = mem[rd_idx];
endmodule

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: collects a byte frame, streams it bit-serially to the CRC LFSR, then idles for the CRC shift-out.
// Define SER_MSB_FIRST_EN to serialize each byte MSB first (default LSB first).
module crc_frame_serializer
   import crc_ser_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BYTES  = DEF_MAX_BYTES,
   parameter int CRC_WIDTH  = DEF_CRC_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic                  IN_VALID,
   input  logic                  IN_LAST,
   output logic                  IN_READY,
   output logic                  SER_DATA,
   output logic                  ACTIVE,
   output logic                  FRAME_DONE,
   output logic                  OVF_ERR
);
   localparam int BW = cnt_w(MAX_BYTES + 1);
   localparam int AW = cnt_w(MAX_BYTES);
   localparam int IW = cnt_w(DATA_WIDTH);
   localparam int GW = cnt_w(CRC_WIDTH + 1);
   logic [1:0] state;
   logic [BW-1:0] count, byte_idx, nxt_byte;
   logic [IW-1:0] bit_idx, nxt_bit;
   logic [GW-1:0] gap;
   logic [DATA_WIDTH-1:0] rd_data, cur_byte;
   logic hs, wrap, last_bit, frame_end, gap_done, ser_bit;
   assign hs        = IN_VALID && IN_READY;
   assign wrap      = bit_idx == IW'(DATA_WIDTH - 1);
   assign last_bit  = wrap && byte_idx == count - 1'b1;
   assign frame_end = hs && (IN_LAST || count == BW'(MAX_BYTES - 1));
   assign gap_done  = state == ST_CRC_WAIT && gap == GW'(CRC_WIDTH - 1);
   assign nxt_bit   = (state == ST_SEND && !wrap) ? bit_idx + 1'b1 : '0;
   assign nxt_byte  = (state == ST_SEND) ? byte_idx + BW'(wrap) : '0;
   // the first bit leaves on the last-byte handshake edge, before a lone byte reaches the buffer
   assign cur_byte  = (state == ST_COLLECT && count == '0) ? IN_DATA : rd_data;
`ifdef SER_MSB_FIRST_EN
   assign ser_bit = cur_byte[IW'(DATA_WIDTH - 1) - nxt_bit];
`else
   assign ser_bit = cur_byte[nxt_bit];
`endif
   crc_ser_buf #(.DW(DATA_WIDTH), .MB(MAX_BYTES), .BW(BW), .AW(AW)) u_buf (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (hs),
      .clr     (gap_done),
      .wr_data (IN_DATA),
      .rd_idx  (nxt_byte[AW-1:0]),
      .count   (count),
      .rd_data (rd_data)
   );
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state      <= ST_COLLECT;
         byte_idx   <= '0;
         bit_idx    <= '0;
         gap        <= '0;
         IN_READY   <= 1'b0;
         SER_DATA   <= 1'b0;
         ACTIVE     <= 1'b0;
         FRAME_DONE <= 1'b0;
         OVF_ERR    <= 1'b0;
      end else begin
         FRAME_DONE <= 1'b0;
         OVF_ERR    <= 1'b0;
         case (state)
            ST_COLLECT: begin
               IN_READY <= !frame_end;
               byte_idx <= '0;
               bit_idx  <= '0;
               if (frame_end) begin
                  state    <= ST_SEND;
                  ACTIVE   <= 1'b1;
                  SER_DATA <= ser_bit;
                  OVF_ERR  <= !IN_LAST;
               end
            end
            ST_SEND:
               if (last_bit) begin
                  state    <= ST_CRC_WAIT;
                  ACTIVE   <= 1'b0;
                  SER_DATA <= 1'b0;
                  gap      <= '0;
               end else begin
                  byte_idx <= nxt_byte;
                  bit_idx  <= nxt_bit;
                  SER_DATA <= ser_bit;
               end
            ST_CRC_WAIT:
               if (gap_done) begin
                  state      <= ST_COLLECT;
                  FRAME_DONE <= 1'b1;
                  IN_READY   <= 1'b1;
               end else gap <= gap + 1'b1;
            default: state <= ST_COLLECT;
         endcase
      end
endmodule
